time_setter: RTL and testbench

TIME_SETTER -- requirements
Module: time_setter

---
 rtl/time_setter.sv | 193 +++++++++++++++++++
 tb/tb_time_setter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_setter.sv
// time_setter: three debounced buttons (mode/inc/dec) edit an HH:MM:SS value.
// Optional macro AUTO_REPEAT_EN adds hold-to-repeat on the inc and dec buttons.
module time_setter #(
  parameter int DEB_CYCLES    = 10000,
  parameter int REPEAT_DELAY  = 500000,
  parameter int REPEAT_PERIOD = 200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic [4:0] sethrs,
  output logic [5:0] setmin,
  output logic [5:0] setsec,
  output logic [1:0] field,
  output logic       editing,
  output logic       load
);

  typedef enum logic [1:0] {IDLE = 2'd0, HRS = 2'd1, MIN = 2'd2, SEC = 2'd3} state_t;

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  function automatic logic [4:0] step_hrs(input logic [4:0] v, input logic up);
    logic [4:0] r;
    if (up) r = (v >= 5'd23) ? 5'd0 : v + 5'd1;
    else    r = (v == 5'd0 || v > 5'd23) ? 5'd23 : v - 5'd1;
    return r;
  endfunction

  function automatic logic [5:0] step_60(input logic [5:0] v, input logic up);
    logic [5:0] r;
    if (up) r = (v >= 6'd59) ? 6'd0 : v + 6'd1;
    else    r = (v == 6'd0 || v > 6'd59) ? 6'd59 : v - 6'd1;
    return r;
  endfunction

  // bit 0 = mode, bit 1 = inc, bit 2 = dec throughout
  logic [2:0]    raw_s, sync1_r, sync2_r, deb_r, deb_d_r, press_s;
  logic [DW-1:0] deb_cnt_r [3];
  logic [1:0]    rep_step_s;
  logic          inc_s, dec_s, load_nxt_s;
  state_t        state_r, state_nxt_s;
  logic [4:0]    hrs_r, hrs_nxt_s;
  logic [5:0]    min_r, min_nxt_s, sec_r, sec_nxt_s;
  logic          editing_r, load_r;

  assign raw_s   = {btn_dec, btn_inc, btn_mode};
  assign press_s = deb_r & ~deb_d_r;

  // Two-flop synchronizers for the asynchronous button inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: accept a new level only after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_r   <= 3'b000;
      deb_d_r <= 3'b000;
      for (int i = 0; i < 3; i++) deb_cnt_r[i] <= '0;
    end else begin
      deb_d_r <= deb_r;
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] != deb_r[i]) begin
          if (deb_cnt_r[i] == DW'(DEB_CYCLES - 1)) begin
            deb_r[i]     <= sync2_r[i];
            deb_cnt_r[i] <= '0;
          end else begin
            deb_cnt_r[i] <= deb_cnt_r[i] + DW'(1);
          end
        end else begin
          deb_cnt_r[i] <= '0;
        end
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [1:0]    rep_act_r, rep_first_r;
  logic [RW-1:0] rep_cnt_r [2];

  // Repeat step fires when the held age reaches the first delay, then each period
  always_comb begin
    rep_step_s = 2'b00;
    for (int j = 0; j < 2; j++) begin
      if (rep_first_r[j]) begin
        rep_step_s[j] = rep_act_r[j] && deb_r[j+1] && (rep_cnt_r[j] == RW'(REPEAT_DELAY));
      end else begin
        rep_step_s[j] = rep_act_r[j] && deb_r[j+1] && (rep_cnt_r[j] == RW'(REPEAT_PERIOD));
      end
    end
  end

  // Hold-age counters; any release, mode press or return to IDLE cancels repeating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_act_r   <= 2'b00;
      rep_first_r <= 2'b00;
      for (int j = 0; j < 2; j++) rep_cnt_r[j] <= '0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (press_s[j+1] && !press_s[0] && state_r != IDLE) begin
          rep_act_r[j]   <= 1'b1;
          rep_first_r[j] <= 1'b1;
          rep_cnt_r[j]   <= RW'(1);
        end else if (!rep_act_r[j] || !deb_r[j+1] || press_s[0] || state_r == IDLE) begin
          rep_act_r[j]   <= 1'b0;
          rep_first_r[j] <= 1'b0;
          rep_cnt_r[j]   <= '0;
        end else if (rep_step_s[j]) begin
          rep_first_r[j] <= 1'b0;
          rep_cnt_r[j]   <= RW'(1);
        end else begin
          rep_cnt_r[j]   <= rep_cnt_r[j] + RW'(1);
        end
      end
    end
  end
`else
  assign rep_step_s = 2'b00;
`endif

  assign inc_s = press_s[1] | rep_step_s[0];
  assign dec_s = press_s[2] | rep_step_s[1];

  // Next state and values; mode wins over inc/dec, inc+dec together cancel
  always_comb begin
    state_nxt_s = state_r;
    hrs_nxt_s   = hrs_r;
    min_nxt_s   = min_r;
    sec_nxt_s   = sec_r;
    load_nxt_s  = 1'b0;
    if (press_s[0]) begin
      case (state_r)
        IDLE:    state_nxt_s = HRS;
        HRS:     state_nxt_s = MIN;
        MIN:     state_nxt_s = SEC;
        SEC: begin
          state_nxt_s = IDLE;
          load_nxt_s  = 1'b1;
        end
        default: state_nxt_s = IDLE;
      endcase
    end else if (inc_s != dec_s) begin
      case (state_r)
        HRS:     hrs_nxt_s = step_hrs(hrs_r, inc_s);
        MIN:     min_nxt_s = step_60(min_r, inc_s);
        SEC:     sec_nxt_s = step_60(sec_r, inc_s);
        default: state_nxt_s = state_r;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      hrs_r     <= 5'd0;
      min_r     <= 6'd0;
      sec_r     <= 6'd0;
      editing_r <= 1'b0;
      load_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      hrs_r     <= hrs_nxt_s;
      min_r     <= min_nxt_s;
      sec_r     <= sec_nxt_s;
      editing_r <= (state_nxt_s != IDLE);
      load_r    <= load_nxt_s;
    end
  end

  assign sethrs  = hrs_r;
  assign setmin  = min_r;
  assign setsec  = sec_r;
  assign field   = state_r;
  assign editing = editing_r;
  assign load    = load_r;

endmodule

// File: tb/tb_time_setter.sv
// Self-checking bench for time_setter: randomized button sequences compared
// against a field/modulo model of the editor.
module tb_time_setter;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
  logic [4:0] sethrs;
  logic [5:0] setmin, setsec;
  logic [1:0] field;
  logic editing, load;

  time_setter #(.DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .sethrs(sethrs), .setmin(setmin), .setsec(setsec), .field(field),
    .editing(editing), .load(load)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int load_cnt = 0, cap_h = 0, cap_m = 0, cap_s = 0;
  int m_field = 0, m_h = 0, m_m = 0, m_s = 0, exp_loads = 0;

  // load monitor plus continuous range check
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (load === 1'b1) begin
        load_cnt++;
        cap_h = sethrs; cap_m = setmin; cap_s = setsec;
      end
      n_chk++;
      if (!(sethrs <= 5'd23 && setmin <= 6'd59 && setsec <= 6'd59)) begin
        n_fail++;
        $display("FAIL range: got %0d:%0d:%0d, required hrs<=23 min<=59 sec<=59", sethrs, setmin, setsec);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [19:0] exp_vec();
    logic [4:0] h; logic [5:0] m, s; logic [1:0] f;
    h = m_h[4:0]; m = m_m[5:0]; s = m_s[5:0]; f = m_field[1:0];
    return {h, m, s, f, (m_field != 0)};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // model of one accepted debounced event
  task automatic m_event(input bit md, input bit in, input bit de);
    int d;
    if (md) begin
      if (m_field == 3) begin m_field = 0; exp_loads++; end
      else m_field++;
    end else if (in != de && m_field != 0) begin
      d = in ? 1 : -1;
      if (m_field == 1) m_h = (m_h + d + 24) % 24;
      else if (m_field == 2) m_m = (m_m + d + 60) % 60;
      else m_s = (m_s + d + 60) % 60;
    end
  endtask

  task automatic drive(input bit md, input bit in, input bit de, input int hold);
    {btn_mode, btn_inc, btn_dec} = {md, in, de};
    tick(hold);
    {btn_mode, btn_inc, btn_dec} = 3'b000;
    tick(DEB + 8);
    if (hold >= DEB) m_event(md, in, de);
  endtask

  task automatic do_reset();
    {btn_mode, btn_inc, btn_dec} = 3'b000;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    m_field = 0; m_h = 0; m_m = 0; m_s = 0;
  endtask

  task automatic test_reset();
    int l0;
    do_reset();
    n_chk++;
    if ({sethrs, setmin, setsec, field, editing, load} !== 21'd0) begin
      n_fail++; $display("FAIL reset_state: got %h, required 0", {sethrs, setmin, setsec, field, editing, load});
    end
    drive(1, 0, 0, 6); drive(1, 0, 0, 6); drive(0, 1, 0, 6); drive(0, 1, 0, 6);
    n_chk++;
    if ({sethrs, setmin, setsec, field, editing} !== exp_vec()) begin
      n_fail++; $display("FAIL reset_pre_edit: got %h, required %h", {sethrs, setmin, setsec, field, editing}, exp_vec());
    end
    l0 = load_cnt;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({sethrs, setmin, setsec, field, editing, load} !== 21'd0) begin
      n_fail++; $display("FAIL reset_async: got %h, required 0", {sethrs, setmin, setsec, field, editing, load});
    end
    tick(3);
    rst_n = 1'b1;
    tick(4);
    m_field = 0; m_h = 0; m_m = 0; m_s = 0;
    n_chk++;
    if (load_cnt !== l0) begin
      n_fail++; $display("FAIL reset_no_load: got %0d loads, required %0d", load_cnt, l0);
    end
  endtask

  task automatic test_full_entry();
    int l0;
    do_reset();
    drive(1, 0, 0, 6);
    for (int i = 0; i < 13; i++) drive(0, 1, 0, $urandom_range(7, 4));
    drive(1, 0, 0, 6);
    for (int i = 0; i < 45; i++) drive(0, 1, 0, $urandom_range(7, 4));
    drive(1, 0, 0, 6);
    for (int i = 0; i < 7; i++) drive(0, 1, 0, $urandom_range(7, 4));
    l0 = load_cnt;
    drive(1, 0, 0, 6);
    n_chk++;
    if (load_cnt !== l0 + 1) begin
      n_fail++; $display("FAIL entry_load_count: got %0d, required %0d", load_cnt - l0, 1);
    end
    n_chk++;
    if (cap_h !== 13 || cap_m !== 45 || cap_s !== 7) begin
      n_fail++; $display("FAIL entry_load_values: got %0d:%0d:%0d, required 13:45:7", cap_h, cap_m, cap_s);
    end
    tick(50);
    n_chk++;
    if ({sethrs, setmin, setsec, field, editing} !== exp_vec()) begin
      n_fail++; $display("FAIL entry_held: got %h, required %h", {sethrs, setmin, setsec, field, editing}, exp_vec());
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1, 0, 0, 6);
    drive(0, 0, 1, 6);
    n_chk++;
    if (sethrs !== 5'd23) begin
      n_fail++; $display("FAIL wrap_hrs_dec: got %0d, required 23", sethrs);
    end
    drive(0, 1, 0, 6);
    n_chk++;
    if (sethrs !== 5'd0) begin
      n_fail++; $display("FAIL wrap_hrs_inc: got %0d, required 0", sethrs);
    end
    drive(1, 0, 0, 6); drive(1, 0, 0, 6);
    for (int i = 0; i < 60; i++) drive(0, 1, 0, 5);
    n_chk++;
    if ({sethrs, setmin, setsec, field, editing} !== exp_vec() || setsec !== 6'd0) begin
      n_fail++; $display("FAIL wrap_sec_60: got %h, required %h", {sethrs, setmin, setsec, field, editing}, exp_vec());
    end
    drive(1, 0, 0, 6);
  endtask

  task automatic test_glitch();
    int lat;
    logic [4:0] prev;
    do_reset();
    drive(1, 0, 0, 6);
    drive(0, 1, 0, 3);
    n_chk++;
    if ({sethrs, setmin, setsec, field, editing} !== exp_vec()) begin
      n_fail++; $display("FAIL glitch_3cyc: got %h, required %h", {sethrs, setmin, setsec, field, editing}, exp_vec());
    end
    prev = sethrs; lat = 0;
    btn_inc = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (lat == 0 && sethrs !== prev) lat = k;
    end
    btn_inc = 1'b0;
    tick(DEB + 8);
    m_event(0, 1, 0);
    n_chk++;
    if (lat < DEB + 2 || lat > DEB + 4) begin
      n_fail++; $display("FAIL latency: got %0d cycles, required %0d +/-1", lat, DEB + 3);
    end
    n_chk++;
    if ({sethrs, setmin, setsec, field, editing} !== exp_vec()) begin
      n_fail++; $display("FAIL glitch_10cyc: got %h, required %h", {sethrs, setmin, setsec, field, editing}, exp_vec());
    end
    drive(0, 1, 1, 6);
    n_chk++;
    if ({sethrs, setmin, setsec, field, editing} !== exp_vec()) begin
      n_fail++; $display("FAIL inc_dec_same: got %h, required %h", {sethrs, setmin, setsec, field, editing}, exp_vec());
    end
  endtask

  task automatic test_priority();
    do_reset();
    drive(1, 0, 0, 6);
    drive(1, 1, 0, 6);
    n_chk++;
    if (field !== 2'd2 || sethrs !== 5'd0) begin
      n_fail++; $display("FAIL mode_priority: got field %0d hrs %0d, required field 2 hrs 0", field, sethrs);
    end
    drive(1, 0, 0, 6); drive(1, 0, 0, 6);
    drive(0, 1, 0, 6);
    n_chk++;
    if ({sethrs, setmin, setsec, field, editing} !== exp_vec() || load_cnt !== exp_loads) begin
      n_fail++; $display("FAIL idle_ignore: got %h loads %0d, required %h loads %0d",
                         {sethrs, setmin, setsec, field, editing}, load_cnt, exp_vec(), exp_loads);
    end
  endtask

  task automatic test_random();
    int r, hold;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(9, 0);
      hold = $urandom_range(8, 2);
      case (r)
        0, 1:    drive(1, 0, 0, hold);
        2, 3, 4: drive(0, 1, 0, hold);
        5, 6, 7: drive(0, 0, 1, hold);
        8:       drive(0, 1, 1, hold);
        default: drive(1, 1, 0, hold);
      endcase
      n_chk++;
      if ({sethrs, setmin, setsec, field, editing} !== exp_vec() || load_cnt !== exp_loads) begin
        n_fail++; $display("FAIL random_%0d op %0d hold %0d: got %h loads %0d, required %h loads %0d",
                           i, r, hold, {sethrs, setmin, setsec, field, editing}, load_cnt, exp_vec(), exp_loads);
      end
    end
  endtask

  task automatic test_auto_repeat();
    int steps, hold;
    do_reset();
    drive(1, 0, 0, 6); drive(1, 0, 0, 6);
    hold = 40;
    btn_inc = 1'b1;
    tick(hold);
    btn_inc = 1'b0;
    tick(DEB + 8);
`ifdef AUTO_REPEAT_EN
    steps = 1 + (((hold - 1) >= RD) ? ((hold - 1 - RD) / RP + 1) : 0);
`else
    steps = 1;
`endif
    m_m = (m_m + steps) % 60;
    n_chk++;
    if ({sethrs, setmin, setsec, field, editing} !== exp_vec()) begin
      n_fail++; $display("FAIL auto_repeat: got min %0d, required %0d", setmin, m_m);
    end
  endtask

  initial begin
    test_reset();
    test_full_entry();
    test_wrap();
    test_glitch();
    test_priority();
    test_random();
    test_auto_repeat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
